ex_stage: RTL and testbench

Execute stage of the MINA2000 five-stage pipeline, directly downstream of the ID/EX register; it consumes the registered `ex_params_t` bundle. It computes the ALU result, maintains the architectural T flag, and resolves branches. On a taken branch it issues a fetch redirect and drives `valid` low to squash the ID/EX and IF/ID registers. Results are registered into the EX/WB bundle, and that registered result is forwarded back to the next instruction.

---
 rtl/ex_stage.sv | 189 ++++++++++++++++++
 tb/tb_ex_stage.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// -----------------------------------------------------------------------------
// types   : widths, encodings and the ID/EX bundle that feeds the execute stage.
// ex_stage: execute stage of the MINA2000 five-stage pipeline.
//
// The stage builds the ALU operands, computes the ALU result and keeps the
// architectural T flag. It also resolves branches. A taken branch issues a fetch
// redirect and pulls `valid` low for one cycle, which squashes ID/EX and IF/ID.
// Results are registered into the EX/WB bundle. That registered result is
// forwarded back to the next instruction, so dependent instructions can run
// back to back.
//
// Ports
//   clk           in   1   rising-edge clock
//   rst           in   1   synchronous, active-high reset
//   ex_params     in   ex_params_t  registered ID/EX bundle
//   valid         out  1   0 squashes ID/EX and IF/ID at the next edge
//   redirect      out  1   taken branch this cycle
//   redirect_addr out  32  fetch target, word aligned
//   wb_en         out  1   registered write enable
//   wb_addr       out  5   registered destination register
//   wb_data       out  32  registered result / link value
//   t_flag        out  1   current T register
// -----------------------------------------------------------------------------
package types;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   typedef enum logic [1:0] {
      SEL_ZERO = 2'd0,
      SEL_REG  = 2'd1,
      SEL_PC   = 2'd2,
      SEL_IMM  = 2'd3
   } sel_t;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_AND = 3'd1,
      ALU_OR  = 3'd2,
      ALU_XOR = 3'd3,
      ALU_SHL = 3'd4,
      ALU_SHR = 3'd5,
      ALU_SAR = 3'd6
   } alu_op_t;

   typedef enum logic [1:0] {
      T_OP_SET  = 2'd0,
      T_OP_ZERO = 2'd1,
      T_OP_LT   = 2'd2,
      T_OP_LTU  = 2'd3
   } t_op_t;

   typedef struct packed {
      logic [REG_AW-1:0] ra_addr;
      logic [REG_AW-1:0] rb_addr;
      logic [XLEN-1:0]   ra_data;
      logic [XLEN-1:0]   rb_data;
      logic [XLEN-1:0]   imm;
      logic [4:0]        shift;       // left shift applied to imm on operand B
      logic [XLEN-1:0]   ia_plus_4;   // address of this instruction + 4
      logic [REG_AW-1:0] rd_addr;
      sel_t              sel_a;
      sel_t              sel_b;
      logic              invert_b;
      alu_op_t           alu_op;
      logic              update_t;    // instruction writes T
      t_op_t             t_op;
      logic              invert_t;
      logic              branch;
      logic              cond_branch;
   } ex_params_t;

endpackage

module ex_stage
   import types::*;
(
   input  logic              clk,
   input  logic              rst,
   input  ex_params_t        ex_params,
   output logic              valid,
   output logic              redirect,
   output logic [XLEN-1:0]   redirect_addr,
   output logic              wb_en,
   output logic [REG_AW-1:0] wb_addr,
   output logic [XLEN-1:0]   wb_data,
   output logic              t_flag
);

   logic            bubble_q;
   logic            t_q;
   logic [XLEN-1:0] ra, rb;
   logic [XLEN-1:0] op_a, op_b;
   logic [XLEN:0]   sum;
   logic            carry, overflow;
   logic [XLEN-1:0] result;
   logic            t_next;
   logic            taken;

   // Forward only from the EX/WB register. Older results reach us through the
   // register file write-through in ID.
   assign ra = (wb_en && (wb_addr == ex_params.ra_addr) && (ex_params.ra_addr != '0))
               ? wb_data : ex_params.ra_data;
   assign rb = (wb_en && (wb_addr == ex_params.rb_addr) && (ex_params.rb_addr != '0))
               ? wb_data : ex_params.rb_data;

   // NOTE: every variable assigned in an always_comb gets a default first, so no
   // path through the case statements can infer a latch.
   always_comb begin
      op_a = '0;
      unique case (ex_params.sel_a)
         SEL_ZERO: op_a = '0;
         SEL_REG:  op_a = ra;
         SEL_PC:   op_a = ex_params.ia_plus_4 - 32'd4;
         SEL_IMM:  op_a = ex_params.imm;
         default:  op_a = '0;
      endcase

      op_b = '0;
      unique case (ex_params.sel_b)
         SEL_REG: op_b = rb;
         SEL_IMM: op_b = ex_params.imm << ex_params.shift;
         default: op_b = '0;
      endcase
      if (ex_params.invert_b) op_b = ~op_b;
   end

   // The adder always runs, because T_OP_LT / T_OP_LTU need its flags whatever
   // the ALU op. invert_b doubles as the carry-in, which turns ADD into SUB.
   assign sum      = {1'b0, op_a} + {1'b0, op_b} + {{XLEN{1'b0}}, ex_params.invert_b};
   assign carry    = sum[XLEN];
   assign overflow = (op_a[XLEN-1] == op_b[XLEN-1]) && (sum[XLEN-1] != op_a[XLEN-1]);

   always_comb begin
      result = '0;
      unique case (ex_params.alu_op)
         ALU_ADD: result = sum[XLEN-1:0];
         ALU_AND: result = op_a & op_b;
         ALU_OR:  result = op_a | op_b;
         ALU_XOR: result = op_a ^ op_b;
         ALU_SHL: result = op_a << op_b[4:0];
         ALU_SHR: result = op_a >> op_b[4:0];
         ALU_SAR: result = XLEN'($signed(op_a) >>> op_b[4:0]);
         default: result = '0;
      endcase
   end

   always_comb begin
      t_next = 1'b0;
      unique case (ex_params.t_op)
         T_OP_SET:  t_next = 1'b0;
         T_OP_ZERO: t_next = (result == '0);
         T_OP_LT:   t_next = sum[XLEN-1] ^ overflow;
         T_OP_LTU:  t_next = ~carry;
         default:   t_next = 1'b0;
      endcase
   end

   // Branches test the T value from before this instruction's own update.
   assign taken         = !bubble_q && (ex_params.branch || (ex_params.cond_branch && t_q));
   assign redirect      = taken && !rst;
   assign redirect_addr = {result[XLEN-1:2], 2'b00};
   assign valid         = !rst && !taken;
   assign t_flag        = t_q;

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples values from before the edge.
   // NOTE: only the control and result registers take a reset value. A reset
   // edge discards whatever instruction is in EX.
   always_ff @(posedge clk) begin
      if (rst) begin
         bubble_q <= 1'b1;
         t_q      <= 1'b0;
         wb_en    <= 1'b0;
         wb_addr  <= '0;
         wb_data  <= '0;
      end else begin
         // A squash this cycle means ID/EX carries its reset bundle next cycle.
         bubble_q <= ~valid;
         if (!bubble_q && ex_params.update_t)
            t_q <= t_next ^ ex_params.invert_t;
         wb_en   <= !bubble_q && (ex_params.rd_addr != '0);
         wb_addr <= ex_params.rd_addr;
         // Branches write the link value whether or not they are taken.
         wb_data <= (ex_params.branch || ex_params.cond_branch) ? ex_params.ia_plus_4 : result;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// -----------------------------------------------------------------------------
// Testbench for ex_stage. A table of {bundle, expected outputs} records is
// applied one per cycle. Combinational outputs are checked mid-cycle. The
// expected registered outputs are pushed to a scoreboard queue when the bundle
// is driven, then popped and compared after the next rising edge. Hand-written
// sequences cover reset, both at start-up and mid-stream.
// -----------------------------------------------------------------------------
module tb_ex_stage;
   import types::*;

   logic        clk = 1'b0;
   logic        rst;
   ex_params_t  ex_params;
   logic        valid, redirect, wb_en, t_flag;
   logic [31:0] redirect_addr, wb_data;
   logic [4:0]  wb_addr;

   ex_stage dut (
      .clk           (clk),
      .rst           (rst),
      .ex_params     (ex_params),
      .valid         (valid),
      .redirect      (redirect),
      .redirect_addr (redirect_addr),
      .wb_en         (wb_en),
      .wb_addr       (wb_addr),
      .wb_data       (wb_data),
      .t_flag        (t_flag)
   );

   always #5 clk = ~clk;

   typedef struct {
      ex_params_t  p;
      logic        redirect;
      logic [31:0] raddr;
      logic        wb_en;
      logic [31:0] wb_data;
      logic        t;
   } vec_t;

   typedef struct {
      logic        wb_en;
      logic [4:0]  wb_addr;
      logic [31:0] wb_data;
      logic        t;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic ex_params_t mk(
      input alu_op_t alu, input sel_t sa, input sel_t sb_sel,
      input logic [4:0] ra_a, input logic [31:0] ra_d,
      input logic [4:0] rb_a, input logic [31:0] rb_d,
      input logic [31:0] imm, input logic [4:0] sh, input logic inv_b,
      input logic upd, input t_op_t top, input logic inv_t,
      input logic br, input logic cbr, input logic [31:0] ia4, input logic [4:0] rd);
      ex_params_t p;
      p.alu_op = alu;   p.sel_a = sa;       p.sel_b = sb_sel;
      p.ra_addr = ra_a; p.ra_data = ra_d;   p.rb_addr = rb_a; p.rb_data = rb_d;
      p.imm = imm;      p.shift = sh;       p.invert_b = inv_b;
      p.update_t = upd; p.t_op = top;       p.invert_t = inv_t;
      p.branch = br;    p.cond_branch = cbr; p.ia_plus_4 = ia4; p.rd_addr = rd;
      return p;
   endfunction

   function automatic void add(input ex_params_t p, input logic red, input logic [31:0] raddr,
                               input logic we, input logic [31:0] data, input logic t);
      vec_t v;
      v.p = p; v.redirect = red; v.raddr = raddr; v.wb_en = we; v.wb_data = data; v.t = t;
      vecs.push_back(v);
   endfunction

   task automatic apply(input int idx, input vec_t v);
      exp_t e, got;
      @(negedge clk);
      ex_params = v.p;
      #1;
      check($sformatf("v%0d redirect", idx), {31'd0, redirect}, {31'd0, v.redirect});
      check($sformatf("v%0d valid", idx), {31'd0, valid}, {31'd0, !v.redirect});
      if (v.redirect)
         check($sformatf("v%0d redirect_addr", idx), redirect_addr, v.raddr);
      e.wb_en = v.wb_en; e.wb_addr = v.p.rd_addr; e.wb_data = v.wb_data; e.t = v.t;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         failures++;
         $display("FAIL v%0d scoreboard: got empty queue expected one entry", idx);
      end else begin
         got = sb.pop_front();
         check($sformatf("v%0d wb_en", idx), {31'd0, wb_en}, {31'd0, got.wb_en});
         check($sformatf("v%0d t_flag", idx), {31'd0, t_flag}, {31'd0, got.t});
         if (got.wb_en) begin
            check($sformatf("v%0d wb_addr", idx), {27'd0, wb_addr}, {27'd0, got.wb_addr});
            check($sformatf("v%0d wb_data", idx), wb_data, got.wb_data);
         end
      end
   endtask

   initial begin
      //  alu      sa        sb        raA ra_data        rbA rb_data  imm            sh ib ut top        it br cb ia4           rd
      add(mk(ALU_ADD, SEL_ZERO, SEL_IMM, 0, 0,             0,  0,       32'd99,        0, 0, 1, T_OP_SET,  1, 0, 0, 0,            3), 0, 0, 0, 0, 0);
      add(mk(ALU_ADD, SEL_ZERO, SEL_IMM, 0, 0,             0,  0,       32'd5,         0, 0, 0, T_OP_SET,  0, 0, 0, 0,            1), 0, 0, 1, 32'd5, 0);
      add(mk(ALU_ADD, SEL_REG,  SEL_REG, 1, 0,             1,  0,       0,             0, 0, 0, T_OP_SET,  0, 0, 0, 0,            2), 0, 0, 1, 32'd10, 0);
      add(mk(ALU_ADD, SEL_REG,  SEL_REG, 4, 3,             5,  7,       0,             0, 1, 1, T_OP_LT,   0, 0, 0, 0,            6), 0, 0, 1, 32'hFFFF_FFFC, 1);
      add(mk(ALU_ADD, SEL_REG,  SEL_REG, 4, 32'hFFFF_FFFF, 5,  1,       0,             0, 1, 1, T_OP_LTU,  0, 0, 0, 0,            7), 0, 0, 1, 32'hFFFF_FFFE, 0);
      add(mk(ALU_ADD, SEL_ZERO, SEL_ZERO,0, 0,             0,  0,       0,             0, 0, 1, T_OP_SET,  1, 0, 0, 0,            0), 0, 0, 0, 0, 1);
      // Conditional branch on old T=1 while clearing T; aligned target 0x100.
      add(mk(ALU_ADD, SEL_IMM,  SEL_ZERO,0, 0,             0,  0,       32'h103,       0, 0, 1, T_OP_SET,  0, 0, 1, 32'h200,      31), 1, 32'h100, 1, 32'h200, 0);
      // Squashed slot: T_OP_SET with invert_t would set T if not masked.
      add(mk(ALU_ADD, SEL_IMM,  SEL_ZERO,0, 0,             0,  0,       32'h300,       0, 0, 1, T_OP_SET,  1, 0, 1, 32'h204,      8), 0, 0, 0, 0, 0);
      add(mk(ALU_ADD, SEL_PC,   SEL_IMM, 0, 0,             0,  0,       32'h20,        0, 0, 0, T_OP_SET,  0, 1, 0, 32'h44,       31), 1, 32'h60, 1, 32'h44, 0);
      add(mk(ALU_ADD, SEL_IMM,  SEL_ZERO,0, 0,             0,  0,       32'h500,       0, 0, 0, T_OP_SET,  0, 1, 0, 32'h48,       9), 0, 0, 0, 0, 0);
      add(mk(ALU_ADD, SEL_PC,   SEL_IMM, 0, 0,             0,  0,       32'h20,        0, 0, 0, T_OP_SET,  0, 1, 0, 32'h44,       0), 1, 32'h60, 0, 0, 0);
      add(mk(ALU_ADD, SEL_ZERO, SEL_IMM, 0, 0,             0,  0,       32'd7,         0, 0, 0, T_OP_SET,  0, 0, 0, 0,            10), 0, 0, 0, 0, 0);
      // Not-taken conditional branch still writes the link value.
      add(mk(ALU_ADD, SEL_IMM,  SEL_ZERO,0, 0,             0,  0,       32'h700,       0, 0, 0, T_OP_SET,  0, 0, 1, 32'h80,       17), 0, 0, 1, 32'h80, 0);
      add(mk(ALU_SAR, SEL_REG,  SEL_IMM, 10, 32'h8000_0000,0,  0,       32'h24,        0, 0, 0, T_OP_SET,  0, 0, 0, 0,            11), 0, 0, 1, 32'hF800_0000, 0);
      add(mk(ALU_SHL, SEL_REG,  SEL_ZERO,12, 32'h1234_5678,0,  0,       0,             0, 0, 0, T_OP_SET,  0, 0, 0, 0,            12), 0, 0, 1, 32'h1234_5678, 0);
      add(mk(ALU_OR,  SEL_REG,  SEL_IMM, 14, 32'h100,      0,  0,       32'd1,         4, 0, 0, T_OP_SET,  0, 0, 0, 0,            13), 0, 0, 1, 32'h110, 0);
      // rb forwarded from r13 (0x110); nonzero result with invert_t -> T=1.
      add(mk(ALU_AND, SEL_REG,  SEL_REG, 14, 32'hF0F0,     13, 0,       0,             0, 0, 1, T_OP_ZERO, 1, 0, 0, 0,            14), 0, 0, 1, 32'h10, 1);
      add(mk(ALU_SHR, SEL_REG,  SEL_REG, 18, 32'h8000_0000,19, 32'h21,  0,             0, 0, 1, T_OP_ZERO, 0, 0, 0, 0,            16), 0, 0, 1, 32'h4000_0000, 0);
      add(mk(ALU_XOR, SEL_REG,  SEL_REG, 20, 32'd5,        21, 32'd5,   0,             0, 0, 1, T_OP_ZERO, 0, 0, 0, 0,            18), 0, 0, 1, 32'h0, 1);

      // Start-up reset held for two cycles.
      rst = 1'b1;
      ex_params = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset wb_en", {31'd0, wb_en}, 32'd0);
      check("reset t_flag", {31'd0, t_flag}, 32'd0);
      check("reset valid", {31'd0, valid}, 32'd0);
      check("reset redirect", {31'd0, redirect}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      foreach (vecs[i]) apply(i, vecs[i]);

      // Mid-stream reset: a branch that would set T and write r20 is discarded.
      @(negedge clk);
      ex_params = mk(ALU_ADD, SEL_IMM, SEL_ZERO, 0, 0, 0, 0, 32'h900, 0, 0, 1, T_OP_SET, 1, 1, 0, 32'h90, 20);
      rst = 1'b1;
      #1;
      check("midreset valid", {31'd0, valid}, 32'd0);
      check("midreset redirect", {31'd0, redirect}, 32'd0);
      @(posedge clk);
      #1;
      check("midreset wb_en", {31'd0, wb_en}, 32'd0);
      check("midreset t_flag", {31'd0, t_flag}, 32'd0);
      rst = 1'b0;
      // The first slot after release is a bubble, so the branch must not fire.
      @(negedge clk);
      check("post-reset redirect", {31'd0, redirect}, 32'd0);
      check("post-reset valid", {31'd0, valid}, 32'd1);
      @(posedge clk);
      #1;
      check("post-reset wb_en", {31'd0, wb_en}, 32'd0);
      check("post-reset t_flag", {31'd0, t_flag}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
